// File: rtl/gcd_list_reducer_pkg.sv
// Shared field layout for the list reducer's input stream and the GCD unit's
// request message, so the reducer and the GCD unit agree on packing.
package gcd_list_reducer_pkg;

    localparam int P_NBITS_DEFAULT = 16;

    // in_msg = {last, value}
    function automatic int in_last_idx(input int nbits);
        return nbits;
    endfunction

    function automatic int in_value_msb(input int nbits);
        return nbits - 1;
    endfunction

    // gcd_req_msg = {A, B}
    function automatic int req_a_msb(input int nbits);
        return 2 * nbits - 1;
    endfunction

    function automatic int req_a_lsb(input int nbits);
        return nbits;
    endfunction

    function automatic int req_b_msb(input int nbits);
        return nbits - 1;
    endfunction

    localparam int REQ_B_LSB = 0;

    typedef enum logic {
        ACC_SEL_IN   = 1'b0,
        ACC_SEL_RESP = 1'b1
    } acc_sel_t;

endpackage

// File: rtl/gcd_list_reducer_dpath.sv
// Datapath of the list reducer: running result, current element and its
// last flag, plus the short-circuit comparator on the running result.
module gcd_list_reducer_dpath
    import gcd_list_reducer_pkg::*;
#(
    parameter int p_nbits = P_NBITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_nbits:0]       in_msg,
    input  logic [p_nbits-1:0]     gcd_resp_msg,
    input  logic                   acc_en,
    input  acc_sel_t               acc_sel,
    input  logic                   x_en,
    output logic                   in_last,
    output logic                   last_flag,
    output logic                   acc_is_one,
    output logic [2*p_nbits-1:0]   gcd_req_msg,
    output logic [p_nbits-1:0]     out_msg
);

    localparam int LAST_IDX = in_last_idx(p_nbits);
    localparam int VAL_MSB  = in_value_msb(p_nbits);
    localparam int A_MSB    = req_a_msb(p_nbits);
    localparam int A_LSB    = req_a_lsb(p_nbits);
    localparam int B_MSB    = req_b_msb(p_nbits);

    logic [p_nbits-1:0] acc_reg;
    logic [p_nbits-1:0] x_reg;
    logic               last_reg;
    logic [p_nbits-1:0] in_value;
    logic [p_nbits-1:0] acc_d;

    assign in_value = in_msg[VAL_MSB:0];
    assign in_last  = in_msg[LAST_IDX];
    assign acc_d    = (acc_sel == ACC_SEL_RESP) ? gcd_resp_msg : in_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg  <= '0;
            x_reg    <= '0;
            last_reg <= 1'b0;
        end else begin
            if (acc_en) acc_reg <= acc_d;
            if (x_en) begin
                x_reg    <= in_value;
                last_reg <= in_last;
            end
        end
    end

    // Once the running result is 1 the list GCD is settled; skip the unit.
    assign acc_is_one = (acc_reg == {{(p_nbits-1){1'b0}}, 1'b1});
    assign last_flag  = last_reg;

    assign gcd_req_msg[A_MSB:A_LSB]     = acc_reg;
    assign gcd_req_msg[B_MSB:REQ_B_LSB] = x_reg;
    assign out_msg                      = acc_reg;

endmodule

// File: rtl/gcd_list_reducer.sv
// Folds a last-terminated stream of values into its GCD by issuing one
// {running result, element} request at a time to an external GCD unit.
//
// state | meaning
// FIRST | waiting for the first element of a list
// NEXT  | waiting for a further element
// REQ   | presenting {acc, x} to the GCD unit
// WAIT  | waiting for the GCD unit's response
// DONE  | presenting the list result
module gcd_list_reducer
    import gcd_list_reducer_pkg::*;
#(
    parameter int p_nbits = P_NBITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits:0]       in_msg,
    output logic                   gcd_req_val,
    input  logic                   gcd_req_rdy,
    output logic [2*p_nbits-1:0]   gcd_req_msg,
    input  logic                   gcd_resp_val,
    output logic                   gcd_resp_rdy,
    input  logic [p_nbits-1:0]     gcd_resp_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits-1:0]     out_msg
);

    typedef enum logic [2:0] {
        FIRST = 3'd0,
        NEXT  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t   state, state_next;
    logic     acc_en;
    acc_sel_t acc_sel;
    logic     x_en;
    logic     in_last;
    logic     last_flag;
    logic     acc_is_one;

    gcd_list_reducer_dpath #(.p_nbits(p_nbits)) u_dpath (
        .clk          (clk),
        .reset        (reset),
        .in_msg       (in_msg),
        .gcd_resp_msg (gcd_resp_msg),
        .acc_en       (acc_en),
        .acc_sel      (acc_sel),
        .x_en         (x_en),
        .in_last      (in_last),
        .last_flag    (last_flag),
        .acc_is_one   (acc_is_one),
        .gcd_req_msg  (gcd_req_msg),
        .out_msg      (out_msg)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FIRST;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        in_rdy       = 1'b0;
        gcd_req_val  = 1'b0;
        gcd_resp_rdy = 1'b0;
        out_val      = 1'b0;
        acc_en       = 1'b0;
        acc_sel      = ACC_SEL_IN;
        x_en         = 1'b0;
        case (state)
            FIRST: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    acc_en     = 1'b1;
                    state_next = in_last ? DONE : NEXT;
                end
            end
            NEXT: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    x_en = 1'b1;
                    if (acc_is_one) state_next = in_last ? DONE : NEXT;
                    else            state_next = REQ;
                end
            end
            REQ: begin
                gcd_req_val = 1'b1;
                if (gcd_req_rdy) state_next = WAIT;
            end
            WAIT: begin
                gcd_resp_rdy = 1'b1;
                if (gcd_resp_val) begin
                    acc_en     = 1'b1;
                    acc_sel    = ACC_SEL_RESP;
                    state_next = last_flag ? DONE : NEXT;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) state_next = FIRST;
            end
            default: state_next = FIRST;
        endcase
    end

endmodule

// File: tb/tb_gcd_list_reducer.sv
// Scoreboard bench for gcd_list_reducer with a behavioural GCD unit stand-in.
module tb_gcd_list_reducer;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_val;
    logic           in_rdy;
    logic [N:0]     in_msg;
    logic           gcd_req_val;
    logic           gcd_req_rdy;
    logic [2*N-1:0] gcd_req_msg;
    logic           gcd_resp_val;
    logic           gcd_resp_rdy;
    logic [N-1:0]   gcd_resp_msg;
    logic           out_val;
    logic           out_rdy;
    logic [N-1:0]   out_msg;

    logic           model_on = 1'b1;
    logic           model_val;
    logic [N-1:0]   model_msg;
    logic           man_val;
    logic [N-1:0]   man_msg;
    int             resp_delay = 0;

    int errors = 0;
    int checks = 0;
    int req_count = 0;
    logic [2*N-1:0] req_q[$];
    logic [N-1:0]   out_q[$];

    assign gcd_resp_val = model_on ? model_val : man_val;
    assign gcd_resp_msg = model_on ? model_msg : man_msg;

    gcd_list_reducer #(.p_nbits(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_msg       (in_msg),
        .gcd_req_val  (gcd_req_val),
        .gcd_req_rdy  (gcd_req_rdy),
        .gcd_req_msg  (gcd_req_msg),
        .gcd_resp_val (gcd_resp_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .gcd_resp_msg (gcd_resp_msg),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_msg      (out_msg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [N-1:0] gcd_ref(input logic [N-1:0] a_in, input logic [N-1:0] b_in);
        logic [N-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Monitor: pops the scoreboard whenever a request or result transfers.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && gcd_req_val && gcd_req_rdy) begin
                req_count++;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got %h expected none", gcd_req_msg);
                end else check("req_msg", gcd_req_msg, req_q.pop_front());
            end
            if (!reset && out_val && out_rdy) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none", out_msg);
                end else check("out_msg", {16'h0, out_msg}, {16'h0, out_q.pop_front()});
            end
        end
    end

    // GCD unit stand-in: one request at a time, response after resp_delay cycles.
    initial begin
        logic         busy;
        int           cnt;
        logic [N-1:0] pend;
        busy = 1'b0;
        cnt = 0;
        pend = '0;
        model_val = 1'b0;
        model_msg = '0;
        forever begin
            @(negedge clk);
            if (model_on && !reset) begin
                if (!busy) begin
                    if (gcd_req_val && gcd_req_rdy) begin
                        busy = 1'b1;
                        cnt  = resp_delay;
                        pend = gcd_ref(gcd_req_msg[2*N-1:N], gcd_req_msg[N-1:0]);
                    end
                end else if (!model_val) begin
                    if (cnt == 0) begin
                        model_msg = pend;
                        model_val = 1'b1;
                    end else cnt--;
                end
                if (model_val && gcd_resp_rdy) begin
                    @(posedge clk);
                    #1;
                    model_val = 1'b0;
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_accept(input string name);
        int t = 0;
        @(negedge clk);
        while (!in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy) fail_now(name);
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic send(input logic last, input logic [N-1:0] v);
        in_val = 1'b1;
        in_msg = {last, v};
        wait_accept("send_timeout");
    endtask

    task automatic drain();
        int t = 0;
        while ((out_q.size() != 0 || req_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (out_q.size() != 0 || req_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rc;
        int t;
        int wait_cycles;
        reset = 1'b1;
        in_val = 1'b0;
        in_msg = '0;
        gcd_req_rdy = 1'b1;
        out_rdy = 1'b1;
        man_val = 1'b0;
        man_msg = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_req_val", gcd_req_val, 0);
        check("rst_resp_rdy", gcd_resp_rdy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_req_msg", gcd_req_msg, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single element list
        rc = req_count;
        out_q.push_back(16'h0015);
        send(1'b1, 16'h0015);
        check("single_out_val", out_val, 1);
        check("single_out_msg", out_msg, 16'h0015);
        drain();
        check("single_req_count", req_count - rc, 0);

        // 12, 18, 30 -> 6
        req_q.push_back({16'h000C, 16'h0012});
        req_q.push_back({16'h0006, 16'h001E});
        out_q.push_back(16'h0006);
        send(1'b0, 16'h000C);
        send(1'b0, 16'h0012);
        send(1'b1, 16'h001E);
        drain();

        // Short-circuit: 7, 5, 9 -> 1 with a single request
        rc = req_count;
        req_q.push_back({16'h0007, 16'h0005});
        out_q.push_back(16'h0001);
        send(1'b0, 16'h0007);
        send(1'b0, 16'h0005);
        send(1'b1, 16'h0009);
        check("short_out_val_next_cycle", out_val, 1);
        check("short_req_val", gcd_req_val, 0);
        drain();
        check("short_req_count", req_count - rc, 1);

        // Zero operands
        req_q.push_back({16'h0000, 16'h0008});
        out_q.push_back(16'h0008);
        send(1'b0, 16'h0000);
        send(1'b1, 16'h0008);
        drain();
        req_q.push_back({16'h0000, 16'h0000});
        out_q.push_back(16'h0000);
        send(1'b0, 16'h0000);
        send(1'b1, 16'h0000);
        drain();

        // Request and response backpressure: 6, 9 -> 3
        gcd_req_rdy = 1'b0;
        resp_delay = 4;
        out_rdy = 1'b0;
        req_q.push_back({16'h0006, 16'h0009});
        out_q.push_back(16'h0003);
        send(1'b0, 16'h0006);
        send(1'b1, 16'h0009);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_val", gcd_req_val, 1);
            check("bp_req_msg", gcd_req_msg, {16'h0006, 16'h0009});
            check("bp_in_rdy", in_rdy, 0);
        end
        @(posedge clk);
        #1;
        gcd_req_rdy = 1'b1;
        t = 0;
        wait_cycles = 0;
        @(negedge clk);
        while (!out_val && t < 100) begin
            check("bp_wait_in_rdy", in_rdy, 0);
            if (gcd_req_val || gcd_resp_rdy)
                check("bp_wait_req_msg", gcd_req_msg, {16'h0006, 16'h0009});
            if (gcd_resp_rdy) wait_cycles++;
            @(negedge clk);
            t++;
        end
        if (!out_val) fail_now("bp_out_timeout");
        check("bp_wait_len_ge5", (wait_cycles >= 5) ? 1 : 0, 1);

        // Output backpressure: next list is held off until out_go
        @(posedge clk);
        #1;
        in_val = 1'b1;
        in_msg = {1'b1, 16'h0021};
        out_q.push_back(16'h0021);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("obp_out_val", out_val, 1);
            check("obp_out_msg", out_msg, 16'h0003);
            check("obp_in_rdy", in_rdy, 0);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        wait_accept("obp_accept_timeout");
        drain();
        resp_delay = 0;

        // Reset while waiting on the GCD unit
        model_on = 1'b0;
        req_q.push_back({16'h0005, 16'h000A});
        send(1'b0, 16'h0005);
        send(1'b1, 16'h000A);
        t = 0;
        @(negedge clk);
        while (!gcd_resp_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!gcd_resp_rdy) fail_now("wait_state_timeout");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstw_in_rdy", in_rdy, 1);
        check("rstw_resp_rdy", gcd_resp_rdy, 0);
        check("rstw_out_msg", out_msg, 0);
        check("rstw_req_msg", gcd_req_msg, 0);
        man_val = 1'b1;
        man_msg = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale_resp_rdy", gcd_resp_rdy, 0);
            check("stale_in_rdy", in_rdy, 1);
        end
        @(posedge clk);
        #1;
        man_val = 1'b0;
        model_on = 1'b1;
        req_q.push_back({16'h0004, 16'h0006});
        out_q.push_back(16'h0002);
        send(1'b0, 16'h0004);
        send(1'b1, 16'h0006);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
